// File: rtl/loongarch_div_pkg.sv
// Shared definitions for the sequential LoongArch divider.
// Holds the divide/modulo op encodings, the sequencer state encoding and the
// default datapath width and divide-by-zero quotient.
package loongarch_div_pkg;

  localparam int unsigned DIV_XLEN = 32;
  localparam int unsigned DIV_CNT_W = 5;
  localparam logic [DIV_XLEN-1:0] DIV_DBZ_QUOT = 32'hFFFF_FFFF;

  // op[0] = unsigned, op[1] = return remainder
  typedef enum logic [1:0] {
    DIVOP_DIV_W  = 2'b00,
    DIVOP_DIV_WU = 2'b01,
    DIVOP_MOD_W  = 2'b10,
    DIVOP_MOD_WU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/loongarch_div_seq_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   rem     in  XLEN  partial remainder
//   quo     in  XLEN  dividend/quotient shift register
//   divisor in  XLEN  divisor magnitude
//   rem_n   out XLEN  next partial remainder
//   quo_n   out XLEN  next quotient shift register
module div_restore_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_n,
  output logic [XLEN-1:0] quo_n
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    // The shifted remainder can reach 2*divisor-1, so it needs the extra bit.
    rem_sh = {rem, quo[XLEN-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[XLEN-1:0];
      quo_n = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/loongarch_div_seq.sv
// Multi-cycle DIV.W/DIV.WU/MOD.W/MOD.WU unit for the EX stage.
// Accepts one op, stalls the pipeline for 32 restoring steps plus sign fix,
// then pulses done for one cycle with the quotient or remainder on result.
// Ports:
//   clk       in   1     clock, rising edge
//   resetn    in   1     asynchronous active-low reset
//   start     in   1     EX holds a valid div/mod instruction
//   op        in   2     00 DIV.W, 01 DIV.WU, 10 MOD.W, 11 MOD.WU
//   src_a     in   XLEN  dividend
//   src_b     in   XLEN  divisor
//   flush     in   1     abort current operation
//   stall_req out  1     freeze IF/ID/EX
//   busy      out  1     sequencer not idle
//   done      out  1     one-cycle result-valid pulse
//   result    out  XLEN  quotient or remainder, held until the next op completes
module loongarch_div_seq
  import loongarch_div_pkg::*;
#(
  parameter int unsigned      XLEN     = DIV_XLEN,
  parameter int unsigned      CNT_W    = DIV_CNT_W,
  parameter logic [XLEN-1:0]  DBZ_QUOT = DIV_DBZ_QUOT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic            signed_op;

  div_restore_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .divisor(dvs_q),
    .rem_n  (rem_step),
    .quo_n  (quo_step)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    signed_op = ~op_q[0];
    quo_fix   = qneg_q ? -quo_q : quo_q;
    rem_fix   = rneg_q ? -rem_q : rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_PREP;
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
        end
      end
      S_PREP: begin
        // The dividend magnitude seeds the quotient shift register.
        quo_d   = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
        dvs_d   = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;
        rem_d   = '0;
        qneg_d  = signed_op & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        rneg_d  = signed_op & a_q[XLEN-1];
        cnt_d   = '1;
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (b_q == '0) begin
          quo_fix = DBZ_QUOT;
          rem_fix = a_q;
        end
        quo_d = quo_fix;
        rem_d = rem_fix;
        // A flush here must leave the previously returned result intact.
        if (!flush) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Combinational on start so EX does not advance in the accept cycle.
  assign stall_req = ((state_q == S_IDLE) && start && !flush) || (state_q == S_PREP) ||
                     (state_q == S_ITER) || (state_q == S_FIX);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_loongarch_div_seq.sv
module tb_loongarch_div_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  loongarch_div_seq u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall_req(stall_req),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain integer division semantics of the ISA.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  // Issue one op and follow it to done. With hold set, start stays high and the
  // operand inputs wander while busy; the unit must ignore both.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    int k;
    int stall_bad;
    bit seen;
    @(posedge clk);
    #1;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    exp_q.push_back(ref_div(o, a, b));
    last_result = ref_div(o, a, b);
    @(negedge clk);
    chk("accept_stall", {31'd0, stall_req}, 32'd1);
    chk("accept_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    k = 0;
    seen = 0;
    stall_bad = 0;
    while (k < 100 && !seen) begin
      @(negedge clk);
      k++;
      if (done) begin
        seen = 1;
      end else begin
        if (stall_req !== 1'b1 || busy !== 1'b1) stall_bad++;
        if (hold) begin
          op    = 2'($urandom);
          src_a = $urandom;
          src_b = $urandom;
        end
      end
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'd1, 32'd0);
    end else begin
      chk("latency", k, 32'd35);
      chk("done_stall_low", {31'd0, stall_req}, 32'd0);
      chk("stall_window", stall_bad, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[9];

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'd0;
    src_a  = '0;
    src_b  = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    dir[0] = '{2'b00, 32'd100, 32'd7};
    dir[1] = '{2'b10, 32'hFFFF_FF9C, 32'd7};
    dir[2] = '{2'b00, 32'd100, 32'hFFFF_FFF9};
    dir[3] = '{2'b01, 32'hFFFF_FFFF, 32'd2};
    dir[4] = '{2'b11, 32'hFFFF_FFFF, 32'd2};
    dir[5] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF};
    dir[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF};
    dir[7] = '{2'b00, 32'd5, 32'd0};
    dir[8] = '{2'b11, 32'd5, 32'd0};
    foreach (dir[i]) do_op(dir[i].o, dir[i].a, dir[i].b, 1'b0);

    // Flush during cycle 10: no done, IDLE in cycle 11, result untouched.
    @(posedge clk);
    #1;
    op    = 2'b01;
    src_a = 32'd1000;
    src_b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall_req}, 32'd0);
    chk("flush_result", result, last_result);
    do_op(2'b01, 32'd1000, 32'd3, 1'b0);

    do_op(2'b10, 32'hFFFF_F000, 32'd77, 1'b1);

    // Reset asserted mid-operation in cycle 20.
    @(posedge clk);
    #1;
    op    = 2'b00;
    src_a = 32'd12345;
    src_b = 32'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_stall", {31'd0, stall_req}, 32'd0);
    chk("arst_result", result, 32'd0);
    last_result = '0;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom), rand_operand(), rand_operand(), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
